// File: rtl/alu_1_pipe.sv
// Pipelined per-container action ALU: add/sub (optionally saturating), logic, min/max, move.
// LATENCY-deep pipeline with global stall on downstream backpressure; last stage drives outputs.
module alu_1_pipe #(
    parameter int unsigned STAGE_ID   = 0,
    parameter int unsigned ACTION_LEN = 64,
    parameter int unsigned DATA_WIDTH = 48,
    parameter int unsigned OPCODE_LSB = 21,
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned SAT_EN     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ACTION_LEN-1:0] action_in,
    input  logic                  action_valid,
    output logic                  action_ready,
    input  logic [DATA_WIDTH-1:0] operand_1_in,
    input  logic [DATA_WIDTH-1:0] operand_2_in,
    output logic [DATA_WIDTH-1:0] container_out,
    output logic                  container_out_valid,
    input  logic                  container_out_ready,
    output logic                  overflow_out
);

    localparam int unsigned OP_W = 4;

    if (DATA_WIDTH < 8 || DATA_WIDTH > 64) begin : g_bad_width
        $error("alu_1_pipe: DATA_WIDTH out of range");
    end
    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $error("alu_1_pipe: LATENCY out of range");
    end
    if (OPCODE_LSB + OP_W > ACTION_LEN) begin : g_bad_opcode
        $error("alu_1_pipe: opcode field outside action word");
    end

    logic [OP_W-1:0]       opcode;
    logic [DATA_WIDTH:0]   sum_w;
    logic [DATA_WIDTH:0]   diff_w;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_ovf;
    logic                  stall;
    logic                  accept;
    logic                  unused_ok;

    logic                  stg_valid [LATENCY];
    logic                  stg_ovf   [LATENCY];
    logic [DATA_WIDTH-1:0] stg_res   [LATENCY];

    assign opcode = action_in[OPCODE_LSB +: OP_W];
    assign sum_w  = {1'b0, operand_1_in} + {1'b0, operand_2_in};
    assign diff_w = {1'b0, operand_1_in} - {1'b0, operand_2_in};

    // Only the opcode field of the action word is consumed; stage index is informational.
    assign unused_ok = ^{action_in, (STAGE_ID != 0)};

    // Result and carry/borrow flag; MSB of the widened sum/difference is carry/borrow.
    always_comb begin
        alu_res = operand_1_in;
        alu_ovf = 1'b0;
        case (opcode)
            4'b0001, 4'b1001: begin
                alu_ovf = sum_w[DATA_WIDTH];
                alu_res = (SAT_EN != 0 && sum_w[DATA_WIDTH]) ? '1 : sum_w[DATA_WIDTH-1:0];
            end
            4'b0010, 4'b1010: begin
                alu_ovf = diff_w[DATA_WIDTH];
                alu_res = (SAT_EN != 0 && diff_w[DATA_WIDTH]) ? '0 : diff_w[DATA_WIDTH-1:0];
            end
            4'b0101: alu_res = operand_1_in & operand_2_in;
            4'b0110: alu_res = operand_1_in | operand_2_in;
            4'b0111: alu_res = operand_1_in ^ operand_2_in;
            4'b1011: alu_res = (operand_1_in < operand_2_in) ? operand_1_in : operand_2_in;
            4'b1100: alu_res = (operand_1_in < operand_2_in) ? operand_2_in : operand_1_in;
            4'b1110: alu_res = operand_2_in;
            default: alu_res = operand_1_in;
        endcase
    end

    assign stall        = container_out_valid && !container_out_ready;
    assign action_ready = !stall;
    assign accept       = action_valid && !stall;

    // Whole pipeline, bubbles included, advances only when not stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stg_valid[i] <= 1'b0;
                stg_ovf[i]   <= 1'b0;
                stg_res[i]   <= '0;
            end
        end else if (!stall) begin
            stg_valid[0] <= accept;
            stg_ovf[0]   <= alu_ovf;
            stg_res[0]   <= alu_res;
            for (int i = 1; i < LATENCY; i++) begin
                stg_valid[i] <= stg_valid[i-1];
                stg_ovf[i]   <= stg_ovf[i-1];
                stg_res[i]   <= stg_res[i-1];
            end
        end
    end

    assign container_out       = stg_res[LATENCY-1];
    assign container_out_valid = stg_valid[LATENCY-1];
    assign overflow_out        = stg_ovf[LATENCY-1];

endmodule

// File: tb/tb_alu_1_pipe.sv
// Scoreboard bench for alu_1_pipe: a LATENCY=3 non-saturating instance and a LATENCY=1 saturating one.
module tb_alu_1_pipe;

    localparam int unsigned DW    = 48;
    localparam int unsigned AL    = 64;
    localparam int unsigned M_LAT = 3;
    localparam int unsigned S_LAT = 1;

    typedef struct {
        logic [DW-1:0] res;
        logic          ovf;
        int            t;
        int            lat;
        bit            chk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [AL-1:0] m_act = '0, s_act = '0;
    logic          m_av = 1'b0, s_av = 1'b0;
    logic          m_ar, s_ar;
    logic [DW-1:0] m_a = '0, m_b = '0, s_a = '0, s_b = '0;
    logic [DW-1:0] m_out, s_out;
    logic          m_ov, s_ov;
    logic          m_or = 1'b1, s_or = 1'b1;
    logic          m_of, s_of;

    exp_t m_q[$];
    exp_t s_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    bit            held [2];
    logic [DW-1:0] last_res [2];
    logic          last_ovf [2];

    alu_1_pipe #(.STAGE_ID(0), .ACTION_LEN(AL), .DATA_WIDTH(DW), .OPCODE_LSB(21),
                 .LATENCY(M_LAT), .SAT_EN(0)) u_main (
        .clk(clk), .rst(rst), .action_in(m_act), .action_valid(m_av), .action_ready(m_ar),
        .operand_1_in(m_a), .operand_2_in(m_b), .container_out(m_out),
        .container_out_valid(m_ov), .container_out_ready(m_or), .overflow_out(m_of));

    alu_1_pipe #(.STAGE_ID(1), .ACTION_LEN(AL), .DATA_WIDTH(DW), .OPCODE_LSB(21),
                 .LATENCY(S_LAT), .SAT_EN(1)) u_sat (
        .clk(clk), .rst(rst), .action_in(s_act), .action_valid(s_av), .action_ready(s_ar),
        .operand_1_in(s_a), .operand_2_in(s_b), .container_out(s_out),
        .container_out_valid(s_ov), .container_out_ready(s_or), .overflow_out(s_of));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Per-instance output checks at the falling edge.
    task automatic mon(input bit sat, input logic v, input logic ordy, input logic ardy,
                       input logic [DW-1:0] res, input logic ovf);
        int idx;
        exp_t e;
        idx = sat ? 1 : 0;
        check(sat ? "s_action_ready" : "m_action_ready", DW'(ardy), DW'(!(v && !ordy)));
        if (v && !ordy) begin
            if (held[idx]) begin
                check(sat ? "s_hold_res" : "m_hold_res", res, last_res[idx]);
                check(sat ? "s_hold_ovf" : "m_hold_ovf", DW'(ovf), DW'(last_ovf[idx]));
            end
            held[idx]     = 1'b1;
            last_res[idx] = res;
            last_ovf[idx] = ovf;
        end else begin
            held[idx] = 1'b0;
        end
        if (v && ordy) begin
            if ((sat ? s_q.size() : m_q.size()) == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL %s: unexpected result 0x%0h with empty scoreboard", sat ? "s_extra" : "m_extra", res);
            end else begin
                e = sat ? s_q.pop_front() : m_q.pop_front();
                check(sat ? "s_result" : "m_result", res, e.res);
                check(sat ? "s_overflow" : "m_overflow", DW'(ovf), DW'(e.ovf));
                if (e.chk) check(sat ? "s_latency" : "m_latency", DW'(cyc - e.t), DW'(e.lat));
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            held[0] = 1'b0;
            held[1] = 1'b0;
        end else begin
            mon(1'b0, m_ov, m_or, m_ar, m_out, m_of);
            mon(1'b1, s_ov, s_or, s_ar, s_out, s_of);
        end
    end

    // Present one op, wait (bounded) for acceptance, push its expected result.
    task automatic send(input bit sat, input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] er, input logic eo, input bit chk);
        exp_t e;
        int   guard;
        if (sat) begin
            s_act = '0; s_act[24:21] = op; s_a = a; s_b = b; s_av = 1'b1;
        end else begin
            m_act = '0; m_act[24:21] = op; m_a = a; m_b = b; m_av = 1'b1;
        end
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(sat ? s_ar : m_ar) && guard < 50);
        if (!(sat ? s_ar : m_ar)) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: op %b not accepted within %0d cycles", op, guard);
        end else begin
            e.res = er; e.ovf = eo; e.t = cyc; e.lat = sat ? S_LAT : M_LAT; e.chk = chk;
            if (sat) s_q.push_back(e); else m_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (sat) s_av = 1'b0; else m_av = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((m_q.size() != 0 || s_q.size() != 0) && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        #1;
    endtask

    initial begin
        #3;
        check("rst_m_out", m_out, '0);
        check("rst_m_valid", DW'(m_ov), '0);
        check("rst_m_ovf", DW'(m_of), '0);
        check("rst_m_ready", DW'(m_ar), DW'(1));
        check("rst_s_valid", DW'(s_ov), '0);
        check("rst_s_ready", DW'(s_ar), DW'(1));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(0, 4'b0001, 48'h10, 48'h20, 48'h30, 1'b0, 1'b1);
        wait_drain();

        // back-to-back: sub borrow, and, move, empty action
        send(0, 4'b0010, 48'd5, 48'd7, 48'hFFFF_FFFF_FFFE, 1'b1, 1'b1);
        send(0, 4'b0101, 48'hF0F0, 48'hFF00, 48'hF000, 1'b0, 1'b1);
        send(0, 4'b1110, 48'd1, 48'hABC, 48'hABC, 1'b0, 1'b1);
        send(0, 4'b0000, 48'd9, 48'd3, 48'd9, 1'b0, 1'b1);

        send(0, 4'b0001, 48'hFFFF_FFFF_FFFF, 48'd2, 48'd1, 1'b1, 1'b1);
        send(0, 4'b1001, 48'd3, 48'd4, 48'd7, 1'b0, 1'b1);
        send(0, 4'b0110, 48'hF0, 48'h0F, 48'hFF, 1'b0, 1'b1);
        send(0, 4'b0111, 48'hFF, 48'h0F, 48'hF0, 1'b0, 1'b1);
        send(0, 4'b1010, 48'd10, 48'd3, 48'd7, 1'b0, 1'b1);
        send(0, 4'b0010, 48'd7, 48'd7, 48'd0, 1'b0, 1'b1);
        send(0, 4'b0011, 48'h55, 48'h66, 48'h55, 1'b0, 1'b1);
        send(0, 4'b1111, 48'h1234, 48'd5, 48'h1234, 1'b0, 1'b1);
        send(0, 4'b1000, 48'h42, 48'h77, 48'h42, 1'b0, 1'b1);
        send(0, 4'b1011, 48'h8000_0000_0000, 48'd1, 48'd1, 1'b0, 1'b1);
        send(0, 4'b1100, 48'h8000_0000_0000, 48'd1, 48'h8000_0000_0000, 1'b0, 1'b1);

        send(1, 4'b0001, 48'hFFFF_FFFF_FFFF, 48'd2, 48'hFFFF_FFFF_FFFF, 1'b1, 1'b1);
        send(1, 4'b0010, 48'd3, 48'd4, 48'd0, 1'b1, 1'b1);
        send(1, 4'b1001, 48'd1, 48'd2, 48'd3, 1'b0, 1'b1);
        send(1, 4'b1010, 48'd9, 48'd4, 48'd5, 1'b0, 1'b1);
        wait_drain();

        // backpressure: downstream not ready for 5 edges while 4 ops are offered
        @(posedge clk);
        #1;
        m_or = 1'b0;
        fork
            begin
                repeat (5) @(posedge clk);
                #1;
                m_or = 1'b1;
            end
        join_none
        send(0, 4'b0001, 48'd1, 48'd1, 48'd2, 1'b0, 1'b0);
        send(0, 4'b0001, 48'd2, 48'd2, 48'd4, 1'b0, 1'b0);
        send(0, 4'b0111, 48'd6, 48'd3, 48'd5, 1'b0, 1'b0);
        send(0, 4'b1110, 48'd0, 48'h77, 48'h77, 1'b0, 1'b0);
        wait_drain();

        // reset with two ops in flight
        send(0, 4'b0001, 48'd100, 48'd1, 48'd101, 1'b0, 1'b0);
        send(0, 4'b0001, 48'd200, 48'd1, 48'd201, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        m_q.delete();
        check("midrst_out", m_out, '0);
        check("midrst_valid", DW'(m_ov), '0);
        check("midrst_ovf", DW'(m_of), '0);
        check("midrst_ready", DW'(m_ar), DW'(1));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("postrst_valid", DW'(m_ov), '0);
        send(0, 4'b1100, 48'd3, 48'd8, 48'd8, 1'b0, 1'b1);
        wait_drain();

        check("m_queue_empty", DW'(m_q.size()), '0);
        check("s_queue_empty", DW'(s_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_1_pipe.md
# alu_1_pipe

Parametrised, fully pipelined successor to the single-issue stage ALU in the action engine. It sits between the sub-action decoder and the PHV re-assembly logic, one instance per container. Per operation it takes a 4-bit opcode from the action word and two operands, and returns one result container after a configurable latency. It accepts one operation per cycle, honours downstream backpressure, adds logic, min/max and optional saturating arithmetic, and flags overflow.

## Interface
- `STAGE_ID`, 0: stage index; informational only, no behavioural effect.
- `ACTION_LEN`, 64: width of the action word.
- `DATA_WIDTH`, 48: operand/result width; legal range 8..64.
- `OPCODE_LSB`, 21: opcode is `action_in[OPCODE_LSB+3:OPCODE_LSB]`.
- `LATENCY`, 1: accept-to-output cycles; legal range 1..8.
- `SAT_EN`, 0: 1 = unsigned saturation on add/sub results.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `action_in`  in  ACTION_LEN  action word from the sub-action decoder.
- `action_valid`  in  1  operation offered this cycle.
- `action_ready`  out  1  block can accept this cycle.
- `operand_1_in`  in  DATA_WIDTH  first operand, from a PHV container.
- `operand_2_in`  in  DATA_WIDTH  second operand, either a container or an immediate.
- `container_out`  out  DATA_WIDTH  result.
- `container_out_valid`  out  1  result present.
- `container_out_ready`  in  1  downstream accepts the result.
- `overflow_out`  out  1  carry/borrow flag aligned with `container_out`.

## Operation
- Accept when `action_valid && action_ready`. The result is computed combinationally from the operands and opcode, then registered into pipeline stage 1.
- Opcode map; all arithmetic is unsigned and modulo 2^DATA_WIDTH unless `SAT_EN` is set:
  - 0001, 1001: op1 + op2. Overflow = carry out of the MSB.
  - 0010, 1010: op1 − op2. Overflow = borrow, i.e. op1 < op2.
  - 0101: op1 & op2.
  - 0110: op1 | op2.
  - 0111: op1 ^ op2.
  - 1011: min(op1, op2).
  - 1100: max(op1, op2).
  - 1110: op2 (move).
  - All other opcodes, including 0000: op1 (pass-through / empty action).
- `overflow_out` is 0 for every opcode except add and sub.
- With `SAT_EN`=1:
  - An add that overflows yields all-ones.
  - A sub that borrows yields 0.
  - The overflow flag is still reported.
- Pipeline: LATENCY stages. Each stage holds a valid bit, a result and a flag. The last stage drives the outputs.
- Backpressure uses a global stall. `stall = container_out_valid && !container_out_ready`.
  - `action_ready = !stall`, combinational.
  - While stalled, every stage holds its contents and the outputs stay stable.
- Bubbles are not collapsed. An empty stage advances only when the pipeline is not stalled.
- Transfer out occurs when `container_out_valid && container_out_ready`.
- No internal FSM beyond the per-stage valid bits. There are no idle or wait states, and throughput is 1 op/cycle.

## Timing
- Reset values: `container_out`=0, `container_out_valid`=0, `overflow_out`=0, all stage valid bits 0.
- `action_ready`=1 during and after reset, because no output is valid.
- Latency: an op accepted at rising edge N appears on the outputs after edge N+LATENCY−1+1. With `container_out_ready` held high, this is exactly LATENCY cycles after acceptance.
- LATENCY=1: the result register is the output register, and `action_ready` depends combinationally on `container_out_ready`.
- Stall while full with a new `action_valid`: the op is not accepted. The upstream side must hold `action_in` and the operands until `action_ready` is high.
- When `container_out_ready` rises, the pipeline advances on the same edge. If `action_valid` is high, a new op is accepted on that edge.
- Reset asserted mid-operation: all in-flight ops are discarded immediately, asynchronously. The outputs go to their reset values and no partial result is emitted after release.
- The first accept can occur on the first rising edge after `rst` deasserts.

## Test plan
- DATA_WIDTH=48, LATENCY=3, ready held high: add 0x10 + 0x20 in cycle 0 -> `container_out`=0x30, valid high in cycle 3 only, overflow 0.
- Back-to-back ops sub(5,7), and(0xF0F0,0xFF00), move(1,0xABC), opcode 0000 with op1=9 on 4 consecutive cycles -> outputs 0xFFFF_FFFF_FFFE (overflow 1), 0xF000, 0xABC, 9 on 4 consecutive cycles.
- SAT_EN=1: add(0xFFFF_FFFF_FFFF, 2) -> 0xFFFF_FFFF_FFFF, overflow 1; sub(3, 4) -> 0, overflow 1.
- Backpressure: ready low for 5 cycles with 4 ops issued -> `action_ready` drops once the output is valid; output held stable; on release, all 4 results are delivered in order with none lost or duplicated.
- Min/max: min(0x800000000000, 1) -> 1; max(same operands) -> 0x800000000000.
- Assert `rst` with 2 ops in flight -> outputs go to 0 asynchronously; no valid result appears after release until a new op is issued.
